// File: rtl/hex_marquee_if.sv
// Marquee control/display bundle: tick/en/dir strobes in, eight seven-segment digits plus status out.
interface hex_marquee_if;
  logic       tick;
  logic       en;
  logic       dir;
  logic [7:0] HEX7;
  logic [7:0] HEX6;
  logic [7:0] HEX5;
  logic [7:0] HEX4;
  logic [7:0] HEX3;
  logic [7:0] HEX2;
  logic [7:0] HEX1;
  logic [7:0] HEX0;
  logic       busy;
  logic       wrap;

  modport master (
    output tick, en, dir,
    input  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, busy, wrap
  );

  modport slave (
    input  tick, en, dir,
    output HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, busy, wrap
  );
endinterface

// File: rtl/hex_marquee.sv
// Scrolling 8-digit seven-segment marquee over a fixed message ROM padded with 8 blanks.
// Window steps left/right every HOLD_TICKS enabled ticks; display blanks for BLANK_TICKS after a wrap.
module hex_marquee #(
  parameter int MSG_LEN     = 16,
  parameter int HOLD_TICKS  = 4,
  parameter int BLANK_TICKS = 2
) (
  input logic         ck,
  input logic         rs,
  hex_marquee_if.slave bus
);

  localparam int L       = MSG_LEN + 8;
  localparam int HOLD_W  = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
  localparam int BLANK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [4:0]         LAST_POS  = 5'(L - 1);
  localparam logic [5:0]         LEN6      = 6'(L);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  state_t             state;
  logic [4:0]         pos;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [BLANK_W-1:0] blank_cnt;
  logic [7:0]         hex_q [8];
  logic               wrap_q;

  logic [4:0]         step_pos;
  logic               step_wrap;
  logic [4:0]         load_pos;
  logic [7:0]         win   [8];

  // Active-high segment codes; bit7 (DP) is always 0 so the inverted output keeps DP off.
  function automatic logic [7:0] rom_code(input logic [5:0] i);
    logic [7:0] c;
    c = 8'h00;
    if (i < 6'(MSG_LEN)) begin
      case (i[3:0])
        4'd0:    c = 8'h76;
        4'd1:    c = 8'h79;
        4'd2:    c = 8'h38;
        4'd3:    c = 8'h38;
        4'd4:    c = 8'h3F;
        4'd5:    c = 8'h00;
        4'd6:    c = 8'h6F;
        4'd7:    c = 8'h5C;
        4'd8:    c = 8'h5C;
        4'd9:    c = 8'h5E;
        4'd10:   c = 8'h7C;
        4'd11:   c = 8'h6E;
        4'd12:   c = 8'h79;
        4'd13:   c = 8'h00;
        4'd14:   c = 8'h06;
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

  // pos < L and offset <= 7 < L, so a single conditional subtract is a full mod-L.
  function automatic logic [5:0] win_idx(input logic [4:0] p, input int unsigned k);
    logic [5:0] i;
    i = {1'b0, p} + 6'(7 - k);
    if (i >= LEN6) i = i - LEN6;
    return i;
  endfunction

  always_comb begin
    step_wrap = 1'b0;
    if (bus.dir) begin
      step_pos  = (pos == '0) ? LAST_POS : pos - 5'd1;
      step_wrap = (pos == '0);
    end else begin
      step_pos  = (pos == LAST_POS) ? '0 : pos + 5'd1;
      step_wrap = (pos == LAST_POS);
    end

    case (state)
      IDLE:    load_pos = '0;
      SHOW:    load_pos = step_pos;
      default: load_pos = pos;
    endcase

    for (int unsigned k = 0; k < 8; k++) begin
      win[k] = ~rom_code(win_idx(load_pos, k));
    end
  end

  always_ff @(posedge ck) begin
    if (rs) begin
      state     <= IDLE;
      pos       <= '0;
      hold_cnt  <= '0;
      blank_cnt <= '0;
      hex_q     <= '{default: 8'hFF};
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.tick && bus.en) begin
        case (state)
          IDLE: begin
            state    <= SHOW;
            pos      <= '0;
            hold_cnt <= '0;
            hex_q    <= win;
          end
          SHOW: begin
            if (hold_cnt < HOLD_MAX) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              hold_cnt <= '0;
              pos      <= step_pos;
              if (step_wrap) begin
                wrap_q    <= 1'b1;
                state     <= BLANK;
                blank_cnt <= '0;
                hex_q     <= '{default: 8'hFF};
              end else begin
                hex_q <= win;
              end
            end
          end
          BLANK: begin
            if (blank_cnt < BLANK_MAX) begin
              blank_cnt <= blank_cnt + 1'b1;
            end else begin
              state    <= SHOW;
              hold_cnt <= '0;
              hex_q    <= win;
            end
          end
          default: begin
            state <= IDLE;
            hex_q <= '{default: 8'hFF};
          end
        endcase
      end
    end
  end

  assign bus.HEX7 = hex_q[7];
  assign bus.HEX6 = hex_q[6];
  assign bus.HEX5 = hex_q[5];
  assign bus.HEX4 = hex_q[4];
  assign bus.HEX3 = hex_q[3];
  assign bus.HEX2 = hex_q[2];
  assign bus.HEX1 = hex_q[1];
  assign bus.HEX0 = hex_q[0];
  assign bus.busy = (state != IDLE);
  assign bus.wrap = wrap_q;

endmodule
